// File: rtl/periph_pkg.sv
// Register map, TCON bit layout and address decoder shared by the timer peripheral.
// The optional SYSTICK register is decoded only when PERIPH_SYSTICK_EN is defined.
package periph_pkg;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

    localparam int TCON_ENABLE     = 0;
    localparam int TCON_IRQ_EN     = 1;
    localparam int TCON_IRQ_STATUS = 2;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_TH,
        REG_TL,
        REG_TCON,
        REG_SYSTICK
    } reg_sel_e;

    // Exact-match decode: unaligned or unknown offsets fall through to REG_NONE.
    function automatic reg_sel_e decode(input logic [31:0] offset);
        reg_sel_e sel;
        sel = REG_NONE;
        case (offset)
            OFF_TH:      sel = REG_TH;
            OFF_TL:      sel = REG_TL;
            OFF_TCON:    sel = REG_TCON;
`ifdef PERIPH_SYSTICK_EN
            OFF_SYSTICK: sel = REG_SYSTICK;
`endif
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/periph_prescaler.sv
// Tick generator: one tick every PRESCALE clk cycles while enabled.
// Disabling clears the count so the first tick after enabling is PRESCALE cycles out.
module periph_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/periph_timer.sv
// Memory-mapped reload timer with TH/TL/TCON registers and a level interrupt.
// Define PERIPH_SYSTICK_EN to add a free-running read-only SYSTICK counter at 0x14.
module periph_timer
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout
);

    logic [31:0] th;
    logic [31:0] tl;
    logic        enable;
    logic        irq_en;
    logic        irq_status;
    logic [31:0] tcon;
    logic        tick;
    logic        overflow_irq;
    reg_sel_e    sel;

    assign sel = decode(addr - BASE_ADDR);

    periph_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign overflow_irq = tick && (tl == 32'hFFFF_FFFF) && irq_en;

    // Bus writes to TL beat the timer; a hardware overflow beats a software clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th         <= '0;
            tl         <= '0;
            enable     <= 1'b0;
            irq_en     <= 1'b0;
            irq_status <= 1'b0;
        end else begin
            if (wr && sel == REG_TH) begin
                th <= wdata;
            end
            if (wr && sel == REG_TL) begin
                tl <= wdata;
            end else if (tick) begin
                tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
            end
            if (wr && sel == REG_TCON) begin
                enable <= wdata[TCON_ENABLE];
                irq_en <= wdata[TCON_IRQ_EN];
            end
            if (overflow_irq) begin
                irq_status <= 1'b1;
            end else if (wr && sel == REG_TCON) begin
                irq_status <= wdata[TCON_IRQ_STATUS];
            end
        end
    end

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end
`endif

    always_comb begin
        tcon                  = '0;
        tcon[TCON_ENABLE]     = enable;
        tcon[TCON_IRQ_EN]     = irq_en;
        tcon[TCON_IRQ_STATUS] = irq_status;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (sel)
                REG_TH:      rdata = th;
                REG_TL:      rdata = tl;
                REG_TCON:    rdata = tcon;
`ifdef PERIPH_SYSTICK_EN
                REG_SYSTICK: rdata = systick;
`endif
                default:     rdata = '0;
            endcase
        end
    end

    assign irqout = irq_en & irq_status;

endmodule

// File: tb/tb_periph_timer.sv
// Scoreboard bench for periph_timer: one instance with PRESCALE=1, one with PRESCALE=4,
// sharing a bus. SYSTICK checks follow PERIPH_SYSTICK_EN.
module tb_periph_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata1;
    logic [31:0] rdata4;
    logic        irq1;
    logic        irq4;

    always #5 clk = ~clk;

    periph_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata1), .irqout(irq1)
    );

    periph_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata4), .irqout(irq4)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] act;
    int          checks = 0;
    int          passed = 0;

    task automatic push(input string n, input logic [31:0] v);
        exp_t x;
        x.name = n;
        x.val  = v;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rd = 1'b0;
        wr = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
        @(negedge clk);
        wr = 1'b1;
        rd = 1'b0;
        addr = BASE + off;
        wdata = data;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic peek(input logic [31:0] off);
        rd = 1'b1;
        addr = BASE + off;
        #1;
    endtask

    task automatic test_reset();
        push("reset_th", 32'h0);
        push("reset_tl", 32'h0);
        push("reset_tcon", 32'h0);
        push("reset_irq", 32'h0);
        peek(32'h0); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        peek(32'h4); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        peek(32'h8); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        act = {31'b0, irq1}; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_prescale();
        do_reset();
        bus_write(32'h8, 32'h1);
        push("pre4_tl_cycle3", 32'd0);
        push("pre4_tl_cycle4", 32'd1);
        push("pre4_tl_cycle12", 32'd3);
        push("pre1_tl_cycle12", 32'd12);
        repeat (3) @(negedge clk);
        peek(32'h4); act = rdata4; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        @(negedge clk);
        peek(32'h4); act = rdata4; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        repeat (8) @(negedge clk);
        peek(32'h4); act = rdata4; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        bus_write(32'h0, 32'hFFFF_FFF0);
        bus_write(32'h4, 32'hFFFF_FFFE);
        bus_write(32'h8, 32'h3);
        push("ovf_tl_start", 32'hFFFF_FFFE);
        push("ovf_tl_max", 32'hFFFF_FFFF);
        push("ovf_tl_reload", 32'hFFFF_FFF0);
        push("ovf_irqout", 32'h1);
        push("ovf_tcon", 32'h7);
        peek(32'h4); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        @(negedge clk);
        peek(32'h4); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        @(negedge clk);
        peek(32'h4); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        act = {31'b0, irq1}; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        peek(32'h8); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
    endtask

    task automatic test_irq_race();
        do_reset();
        bus_write(32'h4, 32'hFFFF_FFFE);
        bus_write(32'h8, 32'h3);
        bus_write(32'h8, 32'h3);
        push("race_tcon", 32'h7);
        push("race_irqout", 32'h1);
        peek(32'h8); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        act = {31'b0, irq1}; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        bus_write(32'h8, 32'h3);
        push("clear_tcon", 32'h3);
        push("clear_irqout", 32'h0);
        peek(32'h8); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        act = {31'b0, irq1}; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
    endtask

    task automatic test_write_priority();
        do_reset();
        bus_write(32'h8, 32'h1);
        bus_write(32'h4, 32'h0000_1234);
        push("tl_write_wins", 32'h0000_1234);
        push("tl_after_write", 32'h0000_1235);
        push("unmapped_0xc", 32'h0);
        push("rd_low_zero", 32'h0);
        peek(32'h4); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        @(negedge clk);
        peek(32'h4); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        peek(32'hC); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        rd = 1'b0; addr = BASE + 32'h4; #1;
        act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        bus_write(32'h0, 32'h0000_AAAA);
        push("rdw_old_value", 32'h0000_AAAA);
        push("rdw_new_value", 32'h0000_5555);
        @(negedge clk);
        wr = 1'b1; rd = 1'b1; addr = BASE; wdata = 32'h0000_5555; #1;
        act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        @(negedge clk);
        wr = 1'b0;
        peek(32'h0); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
    endtask

    task automatic test_reset_midcount();
        do_reset();
        bus_write(32'h8, 32'h1);
        bus_write(32'h4, 32'd5);
        push("mid_tl_before", 32'd5);
        push("mid_tl_reset", 32'h0);
        push("mid_tcon_reset", 32'h0);
        push("mid_irq_reset", 32'h0);
        peek(32'h4); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        reset = 1'b0;
        peek(32'h4); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        peek(32'h8); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        act = {31'b0, irq1}; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_systick();
        do_reset();
`ifdef PERIPH_SYSTICK_EN
        push("systick_10", 32'd10);
        push("systick_ro", 32'd12);
        repeat (10) @(negedge clk);
        peek(32'h14); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
        bus_write(32'h14, 32'h0);
        peek(32'h14); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
`else
        push("systick_unmapped", 32'h0);
        repeat (10) @(negedge clk);
        peek(32'h14); act = rdata1; e = sb.pop_front(); checks++;
        if (act !== e.val) $display("FAIL %s: got %h, expected %h", e.name, act, e.val); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_overflow();
        test_irq_race();
        test_write_priority();
        test_reset_midcount();
        test_systick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/periph_timer.md
PERIPH_TIMER -- requirements
Module: periph_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_0000, the byte address of the first peripheral register.
REQ-002 SHALL have parameter PRESCALE, default 1, the number of clk cycles per timer tick; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rd  input  1  read strobe from the data bus.
REQ-006 SHALL have port wr  input  1  write strobe from the data bus.
REQ-007 SHALL have port addr  input  32  byte address; only word-aligned offsets are decoded.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  read data.
REQ-010 SHALL have port irqout  output  1  interrupt request to the control unit.

Function
REQ-011 SHALL map the registers TH at offset 0x0, TL at 0x4 and TCON at 0x8 (bit0 enable, bit1 irq_en, bit2 irq_status, bits 31:3 read as 0).
REQ-012 SHALL drive rdata combinationally (zero latency) with the addressed register when rd=1, and with 0 when rd=0 or the address is unmapped.
REQ-013 SHALL perform writes on the rising clk edge when wr=1; writes to unmapped offsets are ignored.
REQ-014 SHALL generate one tick every PRESCALE cycles while TCON.enable=1; with PRESCALE=1 a tick occurs every cycle.
REQ-015 SHALL clear the prescale counter whenever TCON.enable=0 so that the first tick after enabling comes exactly PRESCALE cycles later.
REQ-016 SHALL increment TL by 1 modulo 2^32 on each tick.
REQ-017 SHALL, on a tick with TL=32'hFFFF_FFFF, load TL<=TH instead of wrapping, and set TCON.irq_status if TCON.irq_en=1.
REQ-018 SHALL drive irqout = TCON.irq_en AND TCON.irq_status, registered state only (no combinational path from the bus).
REQ-019 SHALL give a bus write to TL priority over a same-cycle tick or reload.
REQ-020 SHALL give a hardware set of irq_status priority over a same-cycle bus write that clears it, so no overflow is lost.
REQ-021 SHALL leave TH unchanged by the timer; TH changes only via bus writes.
REQ-022 SHALL keep rd and wr independent; simultaneous rd and wr to the same register returns the pre-write value on rdata.

Reset
REQ-023 SHALL, while reset=0, hold TH=0, TL=0, TCON=0, prescale counter=0, irqout=0, independent of clk.
REQ-024 SHALL abandon any in-progress prescale count on reset assertion; counting resumes only after software sets TCON.enable.

Configuration
REQ-025 SHALL, when PERIPH_SYSTICK_EN is defined, add a free-running 32-bit SYSTICK register at offset 0x14, incrementing every clk cycle from 0 after reset, wrapping modulo 2^32, read-only (writes ignored).
REQ-026 SHALL, without PERIPH_SYSTICK_EN, treat offset 0x14 as unmapped (reads 0) and contain no SYSTICK logic.

Structure
REQ-027 SHALL take register offsets (0x0, 0x4, 0x8, 0x14) and TCON bit indices from the shared package periph_pkg.
REQ-028 SHALL implement the prescaler as sub-module periph_prescaler (inputs clk, reset, enable; output tick).

Verification
REQ-029 SHALL cover: reset=0 mid-count with TL=5 -> TL, TCON, irqout read 0 immediately, before next clk edge.
REQ-030 SHALL cover: TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3'b011, PRESCALE=1 -> TL=FFFF_FFFF next cycle, TL=FFFF_FFF0 and irqout=1 the cycle after.
REQ-031 SHALL cover: PRESCALE=4, TL=0, TCON=3'b001 -> TL=1 after exactly 4 cycles, TL=3 after 12 cycles.
REQ-032 SHALL cover: write TCON=3'b011 in the same cycle that an overflow sets irq_status -> irq_status=1, irqout=1.
REQ-033 SHALL cover: write TL=32'h0000_1234 in the same cycle as a tick -> TL=32'h0000_1234; unmapped read at BASE_ADDR+0xC -> rdata=0.
REQ-034 SHALL cover, with PERIPH_SYSTICK_EN: read at offset 0x14 ten cycles after reset release -> value 10; write 0 to 0x14 -> value unaffected.
